// File: rtl/dfh_csr_responder_if.sv
// Request/completion bus between the PF/VF mux (master) and a DFH CSR endpoint (slave).
// One request slot with valid/ready; reads return in-order tagged completions.
interface dfh_csr_responder_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic [7:0]        req_wstrb;
    logic [7:0]        req_tag;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [63:0]       rsp_data;
    logic [7:0]        rsp_tag;
    logic              rsp_unmapped;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_unmapped
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_unmapped
    );
endinterface

// File: rtl/dfh_csr_responder.sv
// DFH CSR endpoint: DFH header, GUID, scratch; DFH_CSR_ACCESS_CNT_EN adds read/write counters at CNT_ADDR.
// Read data one cycle after acceptance; req_ready = !rsp_valid || rsp_ready, writes posted.
module dfh_csr_responder #(
    parameter int                ADDR_W          = 16,
    parameter logic [127:0]      FEATURE_GUID    = 128'h0,
    parameter logic [11:0]       FEATURE_ID      = 12'h0,
    parameter logic [3:0]        FEATURE_REV     = 4'h0,
    parameter logic [3:0]        FEATURE_TYPE    = 4'h1,
    parameter logic [23:0]       NEXT_DFH_OFFSET = 24'h0,
    parameter bit                END_OF_LIST     = 1'b1,
    parameter logic [ADDR_W-1:0] SCRATCH_ADDR    = 'h100,
    parameter logic [ADDR_W-1:0] CNT_ADDR        = 'h38
) (
    input logic                clk,
    input logic                rst_n,
    dfh_csr_responder_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RSP  = 1'b1
    } state_t;

    localparam logic [63:0] DFH_VAL = {FEATURE_TYPE, 19'b0, END_OF_LIST, NEXT_DFH_OFFSET,
                                       FEATURE_REV, FEATURE_ID};

    localparam logic [ADDR_W-4:0] W_DFH    = '0;
    localparam logic [ADDR_W-4:0] W_GUID_L = (ADDR_W-3)'(1);
    localparam logic [ADDR_W-4:0] W_GUID_H = (ADDR_W-3)'(2);
    localparam logic [ADDR_W-4:0] W_SCR    = SCRATCH_ADDR[ADDR_W-1:3];
    localparam logic [ADDR_W-4:0] W_CNT    = CNT_ADDR[ADDR_W-1:3];

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_live;
    logic              w_load;
    logic              w_req_ready;
    logic              w_acc;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic [ADDR_W-4:0] w_word;
    logic [63:0]       w_rd_data;
    logic              w_rd_unmapped;
    logic [63:0]       w_cnt_val;
    logic              w_cnt_mapped;
    logic [63:0]       r_scratch;
    logic [63:0]       r_rsp_data;
    logic [7:0]        r_rsp_tag;
    logic              r_rsp_unmapped;
    logic              w_unused_ok;

    // Byte offset within the 64-bit word carries no meaning for this register file.
    assign w_unused_ok = ^bus.req_addr[2:0];
    assign w_word      = bus.req_addr[ADDR_W-1:3];

    // r_live holds req_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    assign w_req_ready = r_live && ((r_state == ST_IDLE) || bus.rsp_ready);
    assign w_acc       = bus.req_valid && w_req_ready;
    assign w_rd_acc    = w_acc && !bus.req_write;
    assign w_wr_acc    = w_acc && bus.req_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rd_acc) begin
                    w_state_nxt = ST_RSP;
                    w_load      = 1'b1;
                end
            end
            ST_RSP: begin
                if (bus.rsp_ready) begin
                    if (w_rd_acc) begin
                        w_state_nxt = ST_RSP;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef DFH_CSR_ACCESS_CNT_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;
    logic        w_cnt_clr;

    assign w_cnt_clr = w_wr_acc && (w_word == W_CNT) && (bus.req_wstrb == 8'hFF)
                       && (bus.req_wdata == '1);

    // A clear takes priority over counting the clearing write itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_rd_acc && (r_rd_cnt != '1)) begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
            end
            if (w_wr_acc && (r_wr_cnt != '1)) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
        end
    end

    assign w_cnt_val    = {r_rd_cnt, r_wr_cnt};
    assign w_cnt_mapped = 1'b1;
`else
    assign w_cnt_val    = '0;
    assign w_cnt_mapped = 1'b0;
`endif

    always_comb begin
        w_rd_data     = '0;
        w_rd_unmapped = 1'b0;
        if (w_word == W_DFH) begin
            w_rd_data = DFH_VAL;
        end else if (w_word == W_GUID_L) begin
            w_rd_data = FEATURE_GUID[63:0];
        end else if (w_word == W_GUID_H) begin
            w_rd_data = FEATURE_GUID[127:64];
        end else if (w_word == W_SCR) begin
            w_rd_data = r_scratch;
        end else if (w_word == W_CNT) begin
            w_rd_data     = w_cnt_val;
            w_rd_unmapped = !w_cnt_mapped;
        end else begin
            w_rd_unmapped = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scratch <= '0;
        end else if (w_wr_acc && (w_word == W_SCR)) begin
            for (int i = 0; i < 8; i++) begin
                if (bus.req_wstrb[i]) begin
                    r_scratch[8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response registers reload only on an accepted read, so they hold during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data     <= '0;
            r_rsp_tag      <= '0;
            r_rsp_unmapped <= 1'b0;
        end else if (w_load) begin
            r_rsp_data     <= w_rd_data;
            r_rsp_tag      <= bus.req_tag;
            r_rsp_unmapped <= w_rd_unmapped;
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.rsp_valid    = (r_state == ST_RSP);
    assign bus.rsp_data     = r_rsp_data;
    assign bus.rsp_tag      = r_rsp_tag;
    assign bus.rsp_unmapped = r_rsp_unmapped;

endmodule

// File: tb/tb_dfh_csr_responder.sv
// Scoreboard bench for dfh_csr_responder: directed test-plan cases followed by randomized traffic.
`timescale 1ns/1ps
module tb_dfh_csr_responder;
    localparam int           ADDR_W = 16;
    localparam logic [127:0] GUID   = 128'h56E203E9864F49A7B94B12284C31E02B;
    localparam logic [11:0]  FID    = 12'h0;
    localparam logic [3:0]   FREV   = 4'h0;
    localparam logic [3:0]   FTYPE  = 4'h1;
    localparam logic [23:0]  NEXT   = 24'h1000;
    localparam bit           EOL    = 1'b0;
    localparam logic [15:0]  SCR    = 16'h0018;
    localparam logic [15:0]  CNT    = 16'h0038;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dfh_csr_responder_if #(.ADDR_W(ADDR_W)) bus ();

    dfh_csr_responder #(
        .ADDR_W(ADDR_W), .FEATURE_GUID(GUID), .FEATURE_ID(FID), .FEATURE_REV(FREV),
        .FEATURE_TYPE(FTYPE), .NEXT_DFH_OFFSET(NEXT), .END_OF_LIST(EOL),
        .SCRATCH_ADDR(SCR), .CNT_ADDR(CNT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  tag;
        logic        unm;
    } rsp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    rsp_t        exp_q[$];
    logic [63:0] m_scratch = '0;
    logic [31:0] m_rd = '0;
    logic [31:0] m_wr = '0;
    bit          mon_en = 1'b0;
    int          rdy_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: register map from the feature description.
    function automatic rsp_t model_read(input logic [15:0] a, input logic [7:0] tag);
        rsp_t r;
        logic [15:0] off;
        off    = a & 16'hFFF8;
        r.tag  = tag;
        r.unm  = 1'b0;
        r.data = '0;
        if (off == 16'h0)
            r.data = (64'(FTYPE) << 60) | (64'(EOL) << 40) | (64'(NEXT) << 16)
                   | (64'(FREV) << 12) | 64'(FID);
        else if (off == 16'h8)  r.data = GUID[63:0];
        else if (off == 16'h10) r.data = GUID[127:64];
        else if (off == SCR)    r.data = m_scratch;
`ifdef DFH_CSR_ACCESS_CNT_EN
        else if (off == CNT)    r.data = {m_rd, m_wr};
`endif
        else r.unm = 1'b1;
        return r;
    endfunction

    task automatic model_accept(input bit wr, input logic [15:0] a, input logic [63:0] d,
                                input logic [7:0] s, input logic [7:0] tag);
        logic [15:0] off;
        off = a & 16'hFFF8;
        if (!wr) begin
            exp_q.push_back(model_read(a, tag));
`ifdef DFH_CSR_ACCESS_CNT_EN
            if (m_rd != 32'hFFFFFFFF) m_rd++;
`endif
        end else begin
`ifdef DFH_CSR_ACCESS_CNT_EN
            if (off == CNT && s == 8'hFF && d == 64'hFFFFFFFFFFFFFFFF) begin
                m_rd = '0;
                m_wr = '0;
            end else if (m_wr != 32'hFFFFFFFF) begin
                m_wr++;
            end
`endif
            if (off == SCR)
                for (int i = 0; i < 8; i++)
                    if (s[i]) m_scratch[8*i +: 8] = d[8*i +: 8];
        end
    endtask

    // Holds the request until accepted, updates the model, returns at posedge+1.
    task automatic do_req(input bit wr, input logic [15:0] a, input logic [63:0] d,
                          input logic [7:0] s, input logic [7:0] tag);
        int waited;
        waited        = 0;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wstrb = s;
        bus.req_tag   = tag;
        @(negedge clk);
        while (!bus.req_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_accept_timeout: req_ready=%0b after %0d cycles, expected 1", bus.req_ready, waited);
            bus.req_valid = 1'b0;
            return;
        end
        model_accept(wr, a, d, s, tag);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        m_scratch = '0;
        m_rd      = '0;
        m_wr      = '0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 mon_en = 1'b1;
    endtask

    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.rsp_ready = 1'b1;
                1:       bus.rsp_ready = ($urandom_range(0, 3) != 0);
                default: bus.rsp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every completion and checks stall stability.
    initial begin
        rsp_t e;
        rsp_t prev;
        bit   prev_stall;
        prev_stall = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            if (!mon_en || !rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            check("req_ready_rule", bus.req_ready, !bus.rsp_valid || bus.rsp_ready);
            if (prev_stall) begin
                check("stall_valid_held", bus.rsp_valid, 1'b1);
                check("stall_data_stable", bus.rsp_data, prev.data);
                check("stall_tag_stable", bus.rsp_tag, prev.tag);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: tag %h data %h, expected no completion", bus.rsp_tag, bus.rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", bus.rsp_data, e.data);
                    check("rsp_tag", bus.rsp_tag, e.tag);
                    check("rsp_unmapped", bus.rsp_unmapped, e.unm);
                end
            end
            prev_stall = bus.rsp_valid && !bus.rsp_ready;
            prev       = {bus.rsp_data, bus.rsp_tag, bus.rsp_unmapped};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        bus.req_tag   = '0;

        repeat (2) @(negedge clk);
        check("reset_rsp_valid", bus.rsp_valid, 1'b0);
        check("reset_req_ready", bus.req_ready, 1'b0);
        check("reset_rsp_data", bus.rsp_data, 64'h0);
        check("reset_rsp_tag", bus.rsp_tag, 8'h0);
        check("reset_rsp_unmapped", bus.rsp_unmapped, 1'b0);
        #1 rst_n = 1'b1;
        #1 check("release_req_ready_low", bus.req_ready, 1'b0);
        @(posedge clk);
        #1 check("first_clk_req_ready", bus.req_ready, 1'b1);
        mon_en = 1'b1;

        do_req(1'b0, 16'h0008, '0, '0, 8'd3);
        do_req(1'b0, 16'h0010, '0, '0, 8'd4);
        do_req(1'b1, SCR, 64'hDEADBEEF_CAFEF00D, 8'hFF, 8'd0);
        do_req(1'b0, SCR, '0, '0, 8'd5);
        do_req(1'b1, SCR, 64'h0, 8'h0F, 8'd0);
        do_req(1'b0, SCR, '0, '0, 8'd6);
        do_req(1'b1, SCR, 64'hFFFF, 8'h00, 8'd0);
        do_req(1'b0, SCR, '0, '0, 8'd7);
        do_req(1'b1, 16'h0000, 64'h1234, 8'hFF, 8'd0);
        do_req(1'b0, 16'h0000, '0, '0, 8'd8);
        do_req(1'b1, 16'h0008, 64'h1234, 8'hFF, 8'd0);
        do_req(1'b0, 16'h000D, '0, '0, 8'd9);
        do_req(1'b0, 16'h0200, '0, '0, 8'd10);
        drain(50);

        // Completion stall with three queued reads.
        rdy_mode = 2;
        @(posedge clk);
        #2;
        fork
            begin
                do_req(1'b0, 16'h0008, '0, '0, 8'd20);
                do_req(1'b0, 16'h0010, '0, '0, 8'd21);
                do_req(1'b0, SCR, '0, '0, 8'd22);
            end
            begin
                int c;
                c = 0;
                @(negedge clk);
                while (!bus.rsp_valid && c < 50) begin
                    c++;
                    @(negedge clk);
                end
                check("stall_first_valid", bus.rsp_valid, 1'b1);
                repeat (3) begin
                    @(negedge clk);
                    check("stall_req_ready_low", bus.req_ready, 1'b0);
                end
                rdy_mode = 0;
                repeat (3) begin
                    @(negedge clk);
                    check("burst_consecutive_valid", bus.rsp_valid, 1'b1);
                end
            end
        join
        drain(50);

        // Reset while a completion is pending.
        rdy_mode = 2;
        @(posedge clk);
        #2;
        do_req(1'b1, SCR, 64'hA5, 8'hFF, 8'd0);
        do_req(1'b0, 16'h0000, '0, '0, 8'd30);
        check("pre_reset_rsp_valid", bus.rsp_valid, 1'b1);
        mon_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_rsp_valid", bus.rsp_valid, 1'b0);
        check("async_reset_req_ready", bus.req_ready, 1'b0);
        check("async_reset_rsp_data", bus.rsp_data, 64'h0);
        exp_q.delete();
        m_scratch = '0;
        m_rd      = '0;
        m_wr      = '0;
        rdy_mode  = 0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 mon_en = 1'b1;
        do_req(1'b0, SCR, '0, '0, 8'd31);
        drain(50);

        // Access counters (unmapped when the counter feature is compiled out).
        do_reset();
        do_req(1'b1, SCR, 64'h11, 8'hFF, 8'd0);
        do_req(1'b1, 16'h0000, 64'h22, 8'hFF, 8'd0);
        do_req(1'b1, 16'h0200, 64'h33, 8'h01, 8'd0);
        do_req(1'b0, 16'h0008, '0, '0, 8'd40);
        do_req(1'b0, SCR, '0, '0, 8'd41);
        do_req(1'b0, CNT, '0, '0, 8'd42);
        do_req(1'b1, CNT, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 8'd0);
        do_req(1'b0, CNT, '0, '0, 8'd43);
        do_req(1'b0, CNT, '0, '0, 8'd44);
        drain(50);

        // Randomized traffic with random completion backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 400; i++) begin
            bit          wr;
            logic [15:0] a;
            logic [63:0] d;
            logic [7:0]  s;
            wr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       a = 16'h0000;
                1:       a = 16'h0008;
                2:       a = 16'h0010;
                3, 4:    a = SCR;
                5:       a = CNT;
                default: a = 16'($urandom_range(0, 16'h03FF));
            endcase
            a = a | 16'($urandom_range(0, 7));
            d = {$urandom, $urandom};
            s = 8'($urandom_range(0, 255));
            if (wr && $urandom_range(0, 15) == 0) begin
                a = CNT;
                d = 64'hFFFFFFFFFFFFFFFF;
                s = 8'hFF;
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            do_req(wr, a, d, s, 8'(i));
        end
        rdy_mode = 0;
        drain(500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
